hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-step restoring divider or a registered multiplier.
- Holds the pipeline with a stall request while it runs.
- Presents one-cycle hi/lo results plus a HILO write enable, which travel down MEM/WB into the HILO register file and its forwarding path.

Parameters:
- DATA_W, 32, operand/result width; HI and LO are each DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous assertion, active-low
- flush  in  1  pipeline flush; synchronous cancel
- start  in  1  EX holds a mul/div op; held high by EX while stalled
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  in  DATA_W  rs value (multiplicand/dividend)
- operand_b  in  DATA_W  rt value (multiplier/divisor)
- stall_req  out  1  hold IF/ID/EX
- done  out  1  result valid this cycle
- hilo_write_en  out  1  equals done; write HI/LO downstream
- hi_result  out  DATA_W  product[63:32] or remainder
- lo_result  out  DATA_W  product[31:0] or quotient

Behaviour:
- States: IDLE, MUL, DIV_ZERO, DIV_RUN, DONE.
- Reset (rst low, asynchronous): state=IDLE, step counter=0, all result registers=0. Consequently done=0, hilo_write_en=0, stall_req=0, hi_result=0, lo_result=0.
- IDLE:
  - start=1 with op MULT/MULTU → MUL.
  - start=1 with op DIV/DIVU and operand_b==0 → DIV_ZERO.
  - start=1 with op DIV/DIVU and operand_b!=0 → DIV_RUN.
  - Operands and op are latched on this edge; later changes on the inputs are ignored.
- MUL:
  - Registers the 64-bit product: signed (33-bit sign extension) for MULT, zero-extended for MULTU.
  - → DONE.
- DIV_ZERO:
  - hi=operand_a, lo=all ones, for both signed and unsigned.
  - → DONE.
- DIV_RUN:
  - Setup: latch |a| and |b| for DIV, raw values for DIVU; counter=0.
  - One restoring step per cycle: shift {rem,quot} left by 1, trial-subtract the divisor from rem, keep the result if non-negative and set the quotient LSB.
  - After 32 steps (counter==31) → DONE.
- DONE:
  - Sign correction for DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no trap).
  - done=1 and hilo_write_en=1 for exactly one cycle.
  - start is ignored in DONE (it is the same instruction); → IDLE unconditionally.
- stall_req is combinational: (state==IDLE && start && !flush) || state ∈ {MUL, DIV_ZERO, DIV_RUN}. It is 0 in DONE so the instruction advances with its result.
- Latency measured from the start-accept edge T:
  - MUL and DIV_ZERO: done at cycle T+2.
  - DIV: done at cycle T+33.
  - Back-to-back ops are legal: the next start is accepted in the IDLE cycle after DONE.
- flush:
  - In any state: next state=IDLE, no done, no write.
  - flush has priority over start in IDLE and over the DONE write. If flush and done fall in the same cycle, hilo_write_en is forced to 0.
- hi_result and lo_result hold their last value outside DONE. Consumers qualify them with done.
- Reset mid-operation: immediate IDLE; no write is ever issued for the aborted op.

Decomposition:
- Op encodings (MULT/MULTU/DIV/DIVU) and the state encodings go in the shared bus.v-style header alongside the existing DATA_BUS definitions.
- Sub-module div_core: the per-cycle restoring step (rem/quot shift, trial subtract, counter). The FSM, multiplier and sign handling stay in the top module.

Test Plan:
- DIVU 100/7: start at T → stall_req high T..T+32; done at T+33 with lo=14, hi=2; hilo_write_en high for that one cycle only.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT 0xFFFFFFFD (-3) × 5 → done at T+2, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV 1234 / 0 → DIV_ZERO path; done at T+2, hi=1234 (0x000004D2), lo=0xFFFFFFFF.
- Abort cases:
  - flush at T+10 during DIV_RUN → IDLE at T+11; no done/write; stall_req low.
  - Subsequent DIVU 9/3 completes normally: lo=3, hi=0.
  - flush coinciding with DONE → write suppressed.
- Reset and back-to-back:
  - rst low mid-DIV_RUN (asynchronous, between edges) → all outputs 0 immediately.
  - After release, back-to-back MULTU 2×3 then DIVU 7/2 → done at T+2 (lo=6), next start at T+3, done at T+36 (lo=3, hi=1).

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HILO multiply/divide sequencer: op codes, FSM states
// and small op-decoding helpers.
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StMul     = 3'd1,
        StDivZero = 3'd2,
        StDivRun  = 3'd3,
        StDone    = 3'd4
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_core.sv
// One restoring-division step per cycle on unsigned operands. It exposes the
// next remainder/quotient so the caller can capture the final step directly.
module hilo_muldiv_ctrl_div_core #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_last,
    output logic [DATA_W-1:0] o_rem_nxt,
    output logic [DATA_W-1:0] o_quot_nxt
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_div;
    logic [CNT_W-1:0]  r_cnt;

    // The shifted remainder needs one extra bit before the trial subtract.
    logic [DATA_W:0] w_shift;
    logic            w_keep;

    always_comb begin
        w_shift    = {r_rem, r_quot[DATA_W-1]};
        w_keep     = (w_shift >= {1'b0, r_div});
        o_rem_nxt  = w_keep ? DATA_W'(w_shift - {1'b0, r_div}) : w_shift[DATA_W-1:0];
        o_quot_nxt = {r_quot[DATA_W-2:0], w_keep};
        o_last     = (r_cnt == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_div  <= i_divisor;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_rem  <= o_rem_nxt;
            r_quot <= o_quot_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: stalls the pipeline while busy and emits
// a one-cycle HI/LO result with its write enable.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    output logic              o_stall_req,
    output logic              o_done,
    output logic              o_hilo_write_en,
    output logic [DATA_W-1:0] o_hi_result,
    output logic [DATA_W-1:0] o_lo_result
);

    state_e            r_state;
    op_e               r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    op_e                 w_op;
    logic                w_accept;
    logic                w_div_load;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [2*DATA_W-1:0] w_mul_a;
    logic [2*DATA_W-1:0] w_mul_b;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_neg_q;
    logic                w_neg_r;
    logic                w_div_last;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quot_nxt;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_quot_fix;

    always_comb begin
        w_op       = op_e'(i_op);
        w_accept   = (r_state == StIdle) && i_start && !i_flush;
        w_div_load = w_accept && op_is_div(w_op) && (i_operand_b != '0);
        w_abs_a    = (op_is_signed(w_op) && i_operand_a[DATA_W-1]) ? -i_operand_a : i_operand_a;
        w_abs_b    = (op_is_signed(w_op) && i_operand_b[DATA_W-1]) ? -i_operand_b : i_operand_b;
        // Full-width extension gives the same low 64 bits as a 33-bit signed product.
        w_mul_a    = {{DATA_W{op_is_signed(r_op) & r_a[DATA_W-1]}}, r_a};
        w_mul_b    = {{DATA_W{op_is_signed(r_op) & r_b[DATA_W-1]}}, r_b};
        w_prod     = w_mul_a * w_mul_b;
        w_neg_q    = (r_op == OpDiv) && (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
        w_neg_r    = (r_op == OpDiv) && r_a[DATA_W-1];
        w_quot_fix = w_neg_q ? -w_quot_nxt : w_quot_nxt;
        w_rem_fix  = w_neg_r ? -w_rem_nxt : w_rem_nxt;
    end

    hilo_muldiv_ctrl_div_core #(
        .DATA_W(DATA_W)
    ) u_div_core (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_div_load),
        .i_step     (r_state == StDivRun),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_last     (w_div_last),
        .o_rem_nxt  (w_rem_nxt),
        .o_quot_nxt (w_quot_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_op    <= OpMult;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_flush) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_op <= w_op;
                        r_a  <= i_operand_a;
                        r_b  <= i_operand_b;
                        if (!op_is_div(w_op)) begin
                            r_state <= StMul;
                        end else if (i_operand_b == '0) begin
                            r_state <= StDivZero;
                        end else begin
                            r_state <= StDivRun;
                        end
                    end
                end
                StMul: begin
                    r_hi    <= w_prod[2*DATA_W-1:DATA_W];
                    r_lo    <= w_prod[DATA_W-1:0];
                    r_state <= StDone;
                end
                StDivZero: begin
                    r_hi    <= r_a;
                    r_lo    <= '1;
                    r_state <= StDone;
                end
                StDivRun: begin
                    if (w_div_last) begin
                        r_hi    <= w_rem_fix;
                        r_lo    <= w_quot_fix;
                        r_state <= StDone;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Gating with reset keeps every output low while reset is asserted.
    assign o_stall_req     = i_rst_n && (w_accept || (r_state inside {StMul, StDivZero, StDivRun}));
    assign o_done          = (r_state == StDone) && !i_flush;
    assign o_hilo_write_en = o_done;
    assign o_hi_result     = r_hi;
    assign o_lo_result     = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: latency, results, flush and reset aborts,
// back-to-back ops, with hand-computed expectations.
module tb_hilo_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        done;
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    hilo_muldiv_ctrl #(
        .DATA_W(32)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_start         (start),
        .i_op            (op),
        .i_operand_a     (a),
        .i_operand_b     (b),
        .o_stall_req     (stall),
        .o_done          (done),
        .o_hilo_write_en (we),
        .o_hi_result     (hi),
        .o_lo_result     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge in IDLE; drives the op, scrambles the
    // inputs after acceptance and checks stall/done every cycle up to the result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        logic ok;
        ok    = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        check({tag, ":accept_stall"}, {31'd0, stall}, 32'd1);
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == 1) begin
                a  = ~va;
                b  = vb ^ 32'h5a5a_0001;
                op = ~o;
            end
            @(negedge clk);
            if (k < lat && (stall !== 1'b1 || done !== 1'b0 || we !== 1'b0)) ok = 1'b0;
        end
        check({tag, ":busy"}, {31'd0, ok}, 32'd1);
        check({tag, ":done"}, {31'd0, done}, 32'd1);
        check({tag, ":we"}, {31'd0, we}, 32'd1);
        check({tag, ":stall_in_done"}, {31'd0, stall}, 32'd0);
        check({tag, ":hi"}, hi, ehi);
        check({tag, ":lo"}, lo, elo);
        tick();
        start = 1'b0;
    endtask

    task automatic idle_quiet(input string tag, input int n);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || we !== 1'b0 || stall !== 1'b0) ok = 1'b0;
            tick();
        end
        check({tag, ":quiet"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        @(negedge clk);
        check("rst:stall", {31'd0, stall}, 32'd0);
        check("rst:done", {31'd0, done}, 32'd0);
        check("rst:we", {31'd0, we}, 32'd0);
        check("rst:hi", hi, 32'd0);
        check("rst:lo", lo, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        idle_quiet("after_divu", 2);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run_op("div_m100_7", DIV, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run_op("div_100_m7", DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'd2, 32'hFFFF_FFF2);
        run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 33, 32'd0, 32'hFFFF_FFFF);
        run_op("divu_max_msb", DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 33, 32'h7FFF_FFFF, 32'd1);
        run_op("mult_m3_5", MULT, 32'hFFFF_FFFD, 32'd5, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'd1);
        run_op("div_by0", DIV, 32'd1234, 32'd0, 2, 32'h0000_04D2, 32'hFFFF_FFFF);
        run_op("divu_by0", DIVU, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);

        // Flush while the divider is running.
        op    = DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_run:stall_t10", {31'd0, stall}, 32'd1);
        check("flush_run:done_t10", {31'd0, done}, 32'd0);
        tick();
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_run:stall_t11", {31'd0, stall}, 32'd0);
        check("flush_run:we_t11", {31'd0, we}, 32'd0);
        check("flush_run:hi_hold", hi, 32'd5);
        check("flush_run:lo_hold", lo, 32'hFFFF_FFFF);
        tick();
        idle_quiet("flush_run", 40);
        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);

        // Flush landing on the DONE cycle.
        op    = MULT;
        a     = 32'd7;
        b     = 32'd6;
        start = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_done:done", {31'd0, done}, 32'd0);
        check("flush_done:we", {31'd0, we}, 32'd0);
        check("flush_done:stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        start = 1'b0;
        idle_quiet("flush_done", 3);

        // Flush beats start in IDLE.
        op    = DIVU;
        a     = 32'd8;
        b     = 32'd2;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle:stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        idle_quiet("flush_idle", 5);

        // Asynchronous reset in the middle of a divide.
        op    = DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst:stall", {31'd0, stall}, 32'd0);
        check("arst:done", {31'd0, done}, 32'd0);
        check("arst:we", {31'd0, we}, 32'd0);
        check("arst:hi", hi, 32'd0);
        check("arst:lo", lo, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        idle_quiet("arst", 40);

        // Back-to-back: the DIVU is accepted in the IDLE cycle right after DONE.
        run_op("b2b_multu", MULTU, 32'd2, 32'd3, 2, 32'd0, 32'd6);
        run_op("b2b_divu", DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3);
        idle_quiet("b2b", 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
